// File: rtl/core_pkg.sv
// Shared core definitions: data width, result-source encoding, load funct3 codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_pkg;

   localparam int XLEN = 32;

   // Writeback result sources, in result_src index order
   typedef enum logic [1:0] {
      RES_ALU = 2'd0,
      RES_MEM = 2'd1,
      RES_PC4 = 2'd2,
      RES_IMM = 2'd3
   } res_src_e;

   // Load funct3 encodings
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   typedef enum logic {
      WB_IDLE     = 1'b0,
      WB_WAIT_MEM = 1'b1
   } wb_state_e;

endpackage

// File: rtl/load_extend.sv
// Load data extraction: picks byte/half lane from a cache word and sign/zero extends.
// Latency: combinational.
// Backpressure: none.
// Ports: word (cache read word), funct3 (load type), byte_off (addr[1:0]), result (extended value).
module load_extend
   import core_pkg::*;
(
   input  logic [XLEN-1:0] word,
   input  logic [2:0]      funct3,
   input  logic [1:0]      byte_off,
   output logic [XLEN-1:0] result
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = word[7:0];
      case (byte_off)
         2'd0: lane_b = word[7:0];
         2'd1: lane_b = word[15:8];
         2'd2: lane_b = word[23:16];
         2'd3: lane_b = word[31:24];
         default: lane_b = word[7:0];
      endcase
      // Halfword lane only looks at the upper offset bit; misaligned bit 0 is dropped
      lane_h = byte_off[1] ? word[31:16] : word[15:0];

      result = word;
      case (funct3)
         LB:      result = {{24{lane_b[7]}}, lane_b};
         LH:      result = {{16{lane_h[15]}}, lane_h};
         LBU:     result = {24'd0, lane_b};
         LHU:     result = {16'd0, lane_h};
         // LW and the unused encodings pass the whole word
         default: result = word;
      endcase
   end

endmodule

// File: rtl/wb_result_sel.sv
// Writeback result selector: picks one of NUM_SRC sources (or extended load data), registers it.
// Latency: 1 cycle from accept (or from mem_rvalid for a load that missed).
// Backpressure: in_ready drops while waiting for cache data on a load; no downstream stall.
// Ports: clk/rst (sync, active-high); in_valid/in_ready request handshake; result_src,
//        src_data, load_funct3, byte_off, rd_addr, reg_write request fields; mem_rdata/mem_rvalid
//        from the data cache; out_valid/out_result/out_rd/out_we to the register-file write port.
module wb_result_sel
   import core_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int MEM_IDX = int'(RES_MEM),
   // Derived from NUM_SRC; do not override
   parameter int SEL_W   = $clog2(NUM_SRC)
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [SEL_W-1:0]             result_src,
   input  logic [NUM_SRC-1:0][XLEN-1:0] src_data,
   input  logic [2:0]                   load_funct3,
   input  logic [1:0]                   byte_off,
   input  logic [4:0]                   rd_addr,
   input  logic                         reg_write,
   input  logic [XLEN-1:0]              mem_rdata,
   input  logic                         mem_rvalid,
   output logic                         out_valid,
   output logic [XLEN-1:0]              out_result,
   output logic [4:0]                   out_rd,
   output logic                         out_we
);

   wb_state_e       state;
   logic [SEL_W-1:0] sel;
   logic            sel_mem;
   logic            accept;

   // Fields of a load held while the cache refills
   logic [2:0]      pend_funct3;
   logic [1:0]      pend_off;
   logic [4:0]      pend_rd;
   logic            pend_we;

   logic [2:0]      ext_funct3;
   logic [1:0]      ext_off;
   logic [XLEN-1:0] ext_data;

   assign in_ready = (state == WB_IDLE);
   assign accept   = in_valid && in_ready;

   // Out-of-range selects fall back to the ALU result
   always_comb begin
      sel = result_src;
      if (int'(result_src) >= NUM_SRC)
         sel = '0;
   end

   assign sel_mem = (int'(sel) == MEM_IDX);

   // Same extender serves the hit path (live fields) and the refill path (held fields)
   assign ext_funct3 = (state == WB_WAIT_MEM) ? pend_funct3 : load_funct3;
   assign ext_off    = (state == WB_WAIT_MEM) ? pend_off    : byte_off;

   load_extend u_load_extend (
      .word     (mem_rdata),
      .funct3   (ext_funct3),
      .byte_off (ext_off),
      .result   (ext_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= WB_IDLE;
         out_valid   <= 1'b0;
         out_we      <= 1'b0;
         out_result  <= '0;
         out_rd      <= '0;
         pend_funct3 <= '0;
         pend_off    <= '0;
         pend_rd     <= '0;
         pend_we     <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         out_we    <= 1'b0;
         case (state)
            WB_IDLE: begin
               if (accept) begin
                  if (!sel_mem) begin
                     out_valid  <= 1'b1;
                     out_result <= src_data[sel];
                     out_rd     <= rd_addr;
                     out_we     <= reg_write && (rd_addr != 5'd0);
                  end else if (mem_rvalid) begin
                     out_valid  <= 1'b1;
                     out_result <= ext_data;
                     out_rd     <= rd_addr;
                     out_we     <= reg_write && (rd_addr != 5'd0);
                  end else begin
                     pend_funct3 <= load_funct3;
                     pend_off    <= byte_off;
                     pend_rd     <= rd_addr;
                     pend_we     <= reg_write;
                     state       <= WB_WAIT_MEM;
                  end
               end
            end
            WB_WAIT_MEM: begin
               if (mem_rvalid) begin
                  out_valid  <= 1'b1;
                  out_result <= ext_data;
                  out_rd     <= pend_rd;
                  out_we     <= pend_we && (pend_rd != 5'd0);
                  state      <= WB_IDLE;
               end
            end
            default: state <= WB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_result_sel.sv
// Directed-vector bench for wb_result_sel (NUM_SRC=4 main instance, NUM_SRC=3 for select wrap).
// Latency: inputs applied after a clock edge, outputs sampled 1 time unit after the next edge.
// Backpressure: in_ready checked across a cache-miss wait.
module tb_wb_result_sel;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       result_src;
   logic [3:0][31:0] src_data;
   logic [2:0]       load_funct3;
   logic [1:0]       byte_off;
   logic [4:0]       rd_addr;
   logic             reg_write;
   logic [31:0]      mem_rdata;
   logic             mem_rvalid;
   logic             out_valid;
   logic [31:0]      out_result;
   logic [4:0]       out_rd;
   logic             out_we;

   // NUM_SRC=3 instance shares control inputs
   logic [1:0]       result_src3;
   logic [2:0][31:0] src_data3;
   logic             in_ready3;
   logic             out_valid3;
   logic [31:0]      out_result3;
   logic [4:0]       out_rd3;
   logic             out_we3;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   wb_result_sel #(.NUM_SRC(4), .MEM_IDX(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .result_src(result_src), .src_data(src_data), .load_funct3(load_funct3),
      .byte_off(byte_off), .rd_addr(rd_addr), .reg_write(reg_write),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .out_valid(out_valid),
      .out_result(out_result), .out_rd(out_rd), .out_we(out_we)
   );

   wb_result_sel #(.NUM_SRC(3), .MEM_IDX(1)) dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
      .result_src(result_src3), .src_data(src_data3), .load_funct3(load_funct3),
      .byte_off(byte_off), .rd_addr(rd_addr), .reg_write(reg_write),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .out_valid(out_valid3),
      .out_result(out_result3), .out_rd(out_rd3), .out_we(out_we3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mem_req(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] data,
                          input logic rv);
      in_valid    = 1'b1;
      result_src  = 2'd1;
      load_funct3 = f3;
      byte_off    = off;
      mem_rdata   = data;
      mem_rvalid  = rv;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; result_src = 2'd0; src_data = '0;
      load_funct3 = 3'b000; byte_off = 2'd0; rd_addr = 5'd0; reg_write = 1'b0;
      mem_rdata = '0; mem_rvalid = 1'b0; result_src3 = 2'd0; src_data3 = '0;
      tick(); tick();
      rst = 1'b0;
      check("rst_valid", out_valid, 0);
      check("rst_we", out_we, 0);
      check("rst_result", out_result, 0);
      check("rst_rd", out_rd, 0);
      check("rst_ready", in_ready, 1);

      // ALU select
      src_data[0] = 32'h0000_1234; rd_addr = 5'd5; reg_write = 1'b1;
      in_valid = 1'b1; result_src = 2'd0;
      tick();
      check("alu_valid", out_valid, 1);
      check("alu_result", out_result, 32'h0000_1234);
      check("alu_rd", out_rd, 5);
      check("alu_we", out_we, 1);
      in_valid = 1'b0;
      tick();
      check("idle_valid", out_valid, 0);
      check("idle_we", out_we, 0);
      check("idle_hold", out_result, 32'h0000_1234);
      check("idle_hold_rd", out_rd, 5);

      // Load hits, back to back
      rd_addr = 5'd9;
      mem_req(3'b000, 2'd2, 32'h80FF_7F01, 1'b1); tick();
      check("lb_valid", out_valid, 1);
      check("lb_off2", out_result, 32'hFFFF_FFFF);
      check("lb_rd", out_rd, 9);
      mem_req(3'b100, 2'd3, 32'h80FF_7F01, 1'b1); tick();
      check("lbu_off3", out_result, 32'h0000_0080);
      mem_req(3'b001, 2'd1, 32'h80FF_7F01, 1'b1); tick();
      check("lh_off1", out_result, 32'h0000_7F01);
      mem_req(3'b001, 2'd2, 32'h80FF_7F01, 1'b1); tick();
      check("lh_off2", out_result, 32'hFFFF_80FF);
      mem_req(3'b010, 2'd3, 32'h80FF_7F01, 1'b1); tick();
      check("lw_off3", out_result, 32'h80FF_7F01);
      mem_req(3'b111, 2'd1, 32'h80FF_7F01, 1'b1); tick();
      check("f3_111_lw", out_result, 32'h80FF_7F01);
      mem_req(3'b000, 2'd1, 32'h1234_8000, 1'b1); tick();
      check("lb_off1_neg", out_result, 32'hFFFF_FF80);
      check("hit_valid", out_valid, 1);

      // Stray rvalid with no accept
      in_valid = 1'b0; mem_rvalid = 1'b1; tick();
      check("stray_rvalid", out_valid, 0);
      mem_rvalid = 1'b0;

      // Miss: LHU off2, fields changed while waiting must not matter
      rd_addr = 5'd7; reg_write = 1'b1;
      mem_req(3'b101, 2'd2, 32'hDEAD_BEEF, 1'b0); tick();
      check("miss_accept_valid", out_valid, 0);
      check("miss_ready0", in_ready, 0);
      in_valid = 1'b0; load_funct3 = 3'b000; byte_off = 2'd0; rd_addr = 5'd3; reg_write = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("miss_wait_ready", in_ready, 0);
         check("miss_wait_valid", out_valid, 0);
      end
      mem_rdata = 32'h8001_0000; mem_rvalid = 1'b1; tick();
      check("miss_valid", out_valid, 1);
      check("miss_result", out_result, 32'h0000_8001);
      check("miss_rd", out_rd, 7);
      check("miss_we", out_we, 1);
      check("miss_ready1", in_ready, 1);
      mem_rvalid = 1'b0; tick();
      check("miss_pulse_end", out_valid, 0);

      // Back-to-back PC4 / IMM / ALU
      src_data[0] = 32'h0000_0055; src_data[2] = 32'h0000_1004; src_data[3] = 32'hABCD_0000;
      in_valid = 1'b1; reg_write = 1'b1; rd_addr = 5'd10; result_src = 2'd2; tick();
      check("pc4_result", out_result, 32'h0000_1004);
      check("pc4_rd", out_rd, 10);
      rd_addr = 5'd11; result_src = 2'd3; tick();
      check("imm_valid", out_valid, 1);
      check("imm_result", out_result, 32'hABCD_0000);
      rd_addr = 5'd12; result_src = 2'd0; tick();
      check("alu2_valid", out_valid, 1);
      check("alu2_result", out_result, 32'h0000_0055);
      check("alu2_rd", out_rd, 12);

      // Out-of-range select on the 3-source instance falls back to ALU
      src_data3[0] = 32'hCAFE_0003; src_data3[2] = 32'h0000_0022; result_src3 = 2'd3; tick();
      check("wrap_valid", out_valid3, 1);
      check("wrap_result", out_result3, 32'hCAFE_0003);
      result_src3 = 2'd0;

      // x0 destination
      rd_addr = 5'd0; reg_write = 1'b1; result_src = 2'd0; tick();
      check("x0_valid", out_valid, 1);
      check("x0_we", out_we, 0);
      check("x0_result", out_result, 32'h0000_0055);

      // Reset while a load is pending, then a stale rvalid
      rd_addr = 5'd6;
      mem_req(3'b010, 2'd0, 32'h1111_2222, 1'b0); tick();
      check("rst_wait_ready0", in_ready, 0);
      in_valid = 1'b0; rst = 1'b1; tick();
      rst = 1'b0; mem_rvalid = 1'b1; tick();
      check("rstw_valid", out_valid, 0);
      check("rstw_ready", in_ready, 1);
      check("rstw_result", out_result, 0);
      check("rstw_rd", out_rd, 0);
      check("rstw_we", out_we, 0);
      mem_rvalid = 1'b0; tick();
      check("rstw_valid2", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
